// File: rtl/topmost_pkg.sv
// rtl/topmost_pkg.sv - register map, engine indices and idle default for the debug-port power controller
package topmost_pkg;

  localparam int IDLE_CYCLES_DEF = 16;
  localparam int NUM_REGS        = 11;

  localparam logic [7:0] ADDR_DLX0 = 8'h00;
  localparam logic [7:0] ADDR_DLX1 = 8'h01;
  localparam logic [7:0] ADDR_DLX2 = 8'h02;
  localparam logic [7:0] ADDR_FFT  = 8'h10;
  localparam logic [7:0] ADDR_AES0 = 8'h20;
  localparam logic [7:0] ADDR_AES1 = 8'h21;
  localparam logic [7:0] ADDR_MEM0 = 8'h30;
  localparam logic [7:0] ADDR_MEM1 = 8'h31;
  localparam logic [7:0] ADDR_MEM2 = 8'h32;
  localparam logic [7:0] ADDR_SPI0 = 8'h40;
  localparam logic [7:0] ADDR_SPI1 = 8'h41;

  localparam logic [3:0] IDX_DLX0 = 4'd0;
  localparam logic [3:0] IDX_DLX1 = 4'd1;
  localparam logic [3:0] IDX_DLX2 = 4'd2;
  localparam logic [3:0] IDX_FFT  = 4'd3;
  localparam logic [3:0] IDX_AES0 = 4'd4;
  localparam logic [3:0] IDX_AES1 = 4'd5;
  localparam logic [3:0] IDX_MEM0 = 4'd6;
  localparam logic [3:0] IDX_MEM1 = 4'd7;
  localparam logic [3:0] IDX_MEM2 = 4'd8;
  localparam logic [3:0] IDX_SPI0 = 4'd9;
  localparam logic [3:0] IDX_SPI1 = 4'd10;
  localparam logic [3:0] IDX_NONE = 4'hF;

  typedef enum logic [1:0] {
    ENG_FFT  = 2'd0,
    ENG_AES  = 2'd1,
    ENG_SPI  = 2'd2,
    ENG_NONE = 2'd3
  } eng_e;

  function automatic logic [3:0] reg_index(input logic [7:0] addr);
    case (addr)
      ADDR_DLX0: return IDX_DLX0;
      ADDR_DLX1: return IDX_DLX1;
      ADDR_DLX2: return IDX_DLX2;
      ADDR_FFT:  return IDX_FFT;
      ADDR_AES0: return IDX_AES0;
      ADDR_AES1: return IDX_AES1;
      ADDR_MEM0: return IDX_MEM0;
      ADDR_MEM1: return IDX_MEM1;
      ADDR_MEM2: return IDX_MEM2;
      ADDR_SPI0: return IDX_SPI0;
      ADDR_SPI1: return IDX_SPI1;
      default:   return IDX_NONE;
    endcase
  endfunction

  function automatic eng_e reg_engine(input logic [3:0] idx);
    case (idx)
      IDX_FFT:            return ENG_FFT;
      IDX_AES0, IDX_AES1: return ENG_AES;
      IDX_SPI0, IDX_SPI1: return ENG_SPI;
      default:            return ENG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dap_port.sv
// rtl/dap_port.sv - one debug port: address/data phase decode, address latch, first-data-cycle detect
module dap_port (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus,
  input  logic        en,
  output logic        wr,
  output logic [7:0]  addr,
  output logic [31:0] data,
  output logic        first
);

  logic [7:0]  addr_q;
  logic        addr_valid;
  logic [31:0] prev_word;
  logic        prev_valid;

  // A data word only writes once an address has been latched since reset.
  assign wr    = en & ~bus[31] & addr_valid;
  assign addr  = addr_q;
  assign data  = {1'b0, bus[30:0]};
  assign first = wr & (~prev_valid | (prev_word != bus));

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      addr_valid <= 1'b0;
      prev_word  <= '0;
      prev_valid <= 1'b0;
    end else if (en) begin
      prev_word  <= bus;
      prev_valid <= 1'b1;
      if (bus[31]) begin
        addr_q     <= bus[7:0];
        addr_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/topmost.sv
// rtl/topmost.sv - debug-port register file with engine power gating; DAP_PORT2_EN enables port 2
module topmost
  import topmost_pkg::*;
#(
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF
) (
  input  logic        CLKF,
  input  logic        MASRST,
  input  logic        resPMC,
  input  logic [31:0] DB1,
  input  logic        s1,
  input  logic [31:0] DB2,
  input  logic        s2,
  input  logic        stop,
  input  logic        RDYF,
  input  logic        doneA,
  input  logic        intS,
  input  logic        PauseD,
  output logic        PF,
  output logic        PD,
  output logic        PM,
  output logic        PA,
  output logic        PS,
  output logic [31:0] TP11,
  output logic        TPE11
);

  localparam int CW = $clog2(IDLE_CYCLES + 1);

  logic        p1_wr, p1_first, p2_wr, p2_first, p2_en;
  logic [7:0]  p1_addr, p2_addr;
  logic [31:0] p1_data, p2_data;

`ifdef DAP_PORT2_EN
  assign p2_en = s2 & ~stop;
`else
  logic unused_s2;
  assign unused_s2 = s2;
  assign p2_en     = 1'b0;
`endif

  dap_port u_port1 (
    .clk(CLKF), .rst(MASRST), .bus(DB1), .en(s1 & ~stop),
    .wr(p1_wr), .addr(p1_addr), .data(p1_data), .first(p1_first)
  );

  dap_port u_port2 (
    .clk(CLKF), .rst(MASRST), .bus(DB2), .en(p2_en),
    .wr(p2_wr), .addr(p2_addr), .data(p2_data), .first(p2_first)
  );

  logic        wr_en, wr_first;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_idx;
  logic [2:0]  eng_hit;
  logic [2:0]  eng_done;

  always_comb begin
    wr_en    = 1'b0;
    wr_first = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    if (p1_wr) begin
      wr_en = 1'b1; wr_first = p1_first; wr_addr = p1_addr; wr_data = p1_data;
    end else if (p2_wr) begin
      wr_en = 1'b1; wr_first = p2_first; wr_addr = p2_addr; wr_data = p2_data;
    end
  end

  assign wr_idx   = reg_index(wr_addr);
  assign eng_done = {intS, doneA, RDYF};

  // Only a new data phase wakes an engine; a held word just rewrites its value.
  always_comb begin
    eng_hit = '0;
    if (wr_en && wr_first) begin
      case (reg_engine(wr_idx))
        ENG_FFT: eng_hit[0] = 1'b1;
        ENG_AES: eng_hit[1] = 1'b1;
        ENG_SPI: eng_hit[2] = 1'b1;
        default: ;
      endcase
    end
  end

  logic [31:0]   regs [NUM_REGS];
  logic [CW-1:0] idle_cnt [3];
  logic [2:0]    gated;

  always_ff @(posedge CLKF) begin
    if (MASRST) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en && wr_idx != IDX_NONE) begin
      regs[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge CLKF) begin
    for (int e = 0; e < 3; e++) begin
      if (MASRST || resPMC || eng_hit[e]) begin
        idle_cnt[e] <= '0;
        gated[e]    <= 1'b0;
      end else if (eng_done[e]) begin
        if (idle_cnt[e] == CW'(IDLE_CYCLES - 1)) gated[e] <= 1'b1;
        else idle_cnt[e] <= idle_cnt[e] + CW'(1);
      end else begin
        idle_cnt[e] <= '0;
      end
    end
  end

  always_ff @(posedge CLKF) begin
    if (MASRST) begin
      {PF, PD, PM, PA, PS} <= '0;
      TP11  <= '0;
      TPE11 <= 1'b0;
    end else begin
      PF <= regs[IDX_FFT][0]  & ~gated[ENG_FFT];
      PA <= regs[IDX_AES0][0] & ~gated[ENG_AES];
      PS <= regs[IDX_SPI0][0] & ~gated[ENG_SPI];
      PD <= regs[IDX_DLX0][0] & PauseD;
      PM <= |(regs[IDX_MEM0] | regs[IDX_MEM1] | regs[IDX_MEM2]);
      TPE11 <= p1_first | p2_first;
      if (p1_first)      TP11 <= {p1_addr, p1_data[23:0]};
      else if (p2_first) TP11 <= {p2_addr, p2_data[23:0]};
    end
  end

endmodule

// File: tb/tb_topmost.sv
// tb/tb_topmost.sv - randomized bench for topmost against a register-map level reference model
module tb_topmost;

  localparam int IDLE = 16;
`ifdef DAP_PORT2_EN
  localparam bit PORT2_ON = 1'b1;
`else
  localparam bit PORT2_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        masrst = 1'b1, respmc = 1'b0, s1 = 1'b0, s2 = 1'b0, stop = 1'b0;
  logic        rdyf = 1'b0, donea = 1'b0, ints = 1'b0, paused = 1'b0;
  logic [31:0] db1 = '0, db2 = '0;
  logic        pf, pd, pm, pa, ps, tpe11;
  logic [31:0] tp11;

  always #5 clk = ~clk;

  topmost #(.IDLE_CYCLES(IDLE)) dut (
    .CLKF(clk), .MASRST(masrst), .resPMC(respmc),
    .DB1(db1), .s1(s1), .DB2(db2), .s2(s2), .stop(stop),
    .RDYF(rdyf), .doneA(donea), .intS(ints), .PauseD(paused),
    .PF(pf), .PD(pd), .PM(pm), .PA(pa), .PS(ps), .TP11(tp11), .TPE11(tpe11)
  );

  int tests = 0;
  int failed = 0;

  logic [31:0] m_reg [256];
  logic [7:0]  m_addr [2];
  bit          m_aval [2];
  logic [31:0] m_prev [2];
  bit          m_pval [2];
  int          m_run [3];
  bit          m_gated [3];
  bit          e_pf, e_pd, e_pm, e_pa, e_ps, e_tpe;
  logic [31:0] e_tp;
  logic [7:0]  pick [13] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h20, 8'h21, 8'h30,
                             8'h31, 8'h32, 8'h40, 8'h41, 8'h03, 8'h55};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_mapped(input logic [7:0] a);
    return a inside {8'h00, 8'h01, 8'h02, 8'h10, 8'h20, 8'h21, 8'h30, 8'h31, 8'h32, 8'h40, 8'h41};
  endfunction

  function automatic int eng_of(input logic [7:0] a);
    if (a == 8'h10) return 0;
    if (a == 8'h20 || a == 8'h21) return 1;
    if (a == 8'h40 || a == 8'h41) return 2;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_reg[i] = '0;
    for (int p = 0; p < 2; p++) begin
      m_addr[p] = '0; m_aval[p] = 0; m_prev[p] = '0; m_pval[p] = 0;
    end
    for (int e = 0; e < 3; e++) begin
      m_run[e] = 0; m_gated[e] = 0;
    end
    {e_pf, e_pd, e_pm, e_pa, e_ps, e_tpe} = '0;
    e_tp = '0;
  endtask

  // Advance the model by one rising edge using the inputs present before it.
  task automatic model_edge();
    logic [31:0] word [2];
    bit          en [2], w [2], f [2];
    logic [7:0]  wa [2];
    logic [31:0] wd [2];
    bit          done [3];
    int          win;
    if (masrst) begin
      model_reset();
      return;
    end
    e_pf = m_reg[8'h10][0] && !m_gated[0];
    e_pa = m_reg[8'h20][0] && !m_gated[1];
    e_ps = m_reg[8'h40][0] && !m_gated[2];
    e_pd = m_reg[8'h00][0] && paused;
    e_pm = (m_reg[8'h30] != 0) || (m_reg[8'h31] != 0) || (m_reg[8'h32] != 0);
    word[0] = db1; word[1] = db2;
    en[0] = s1 && !stop; en[1] = PORT2_ON && s2 && !stop;
    for (int p = 0; p < 2; p++) begin
      w[p] = 0; f[p] = 0; wa[p] = m_addr[p]; wd[p] = {1'b0, word[p][30:0]};
      if (en[p]) begin
        if (word[p][31]) begin
          m_addr[p] = word[p][7:0];
          m_aval[p] = 1;
        end else if (m_aval[p]) begin
          w[p] = 1;
          f[p] = !m_pval[p] || (m_prev[p] != word[p]);
        end
        m_prev[p] = word[p];
        m_pval[p] = 1;
      end
    end
    win = w[0] ? 0 : (w[1] ? 1 : -1);
    done[0] = rdyf; done[1] = donea; done[2] = ints;
    for (int e = 0; e < 3; e++) begin
      if (respmc || (win >= 0 && f[win] && eng_of(wa[win]) == e)) begin
        m_run[e] = 0; m_gated[e] = 0;
      end else if (done[e]) begin
        m_run[e]++;
        if (m_run[e] >= IDLE) m_gated[e] = 1;
      end else begin
        m_run[e] = 0;
      end
    end
    if (win >= 0 && is_mapped(wa[win])) m_reg[wa[win]] = wd[win];
    e_tpe = f[0] || f[1];
    if (f[0])      e_tp = {wa[0], wd[0][23:0]};
    else if (f[1]) e_tp = {wa[1], wd[1][23:0]};
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("PF", pf, e_pf);
    check("PD", pd, e_pd);
    check("PM", pm, e_pm);
    check("PA", pa, e_pa);
    check("PS", ps, e_ps);
    check("TPE11", tpe11, e_tpe);
    check("TP11", tp11, e_tp);
  endtask

  task automatic wr1(input logic [7:0] a, input logic [31:0] d);
    db1 = 32'h8000_0000 | a; step();
    db1 = d;                 step();
  endtask

  function automatic logic [31:0] rand_word(input logic [31:0] last);
    int r;
    r = $urandom_range(99);
    if (r < 35) return 32'h8000_0000 | ($urandom & 32'h7fff_ff00) | pick[$urandom_range(12)];
    if (r < 55) return last;
    if (r < 80) return $urandom_range(3);
    return $urandom & 32'h7fff_ffff;
  endfunction

  initial begin
    model_reset();
    step(); step();
    check("rst_TP11", tp11, 32'h0);
    check("rst_PF", pf, 1'b0);
    masrst = 0; s1 = 1;

    wr1(8'h20, 32'h0000_000B);
    check("aes_tpe", tpe11, 1'b1);
    check("aes_tp", tp11, 32'h2000_000B);
    check("aes_reg", dut.regs[4], 32'hB);
    step();
    check("aes_pa", pa, 1'b1);
    check("aes_tpe_once", tpe11, 1'b0);

    paused = 1;
    wr1(8'h00, 32'h23); step();
    check("pd_on", pd, 1'b1);
    paused = 0; step();
    check("pd_off", pd, 1'b0);

    wr1(8'h10, 32'h3); step();
    check("pf_on", pf, 1'b1);
    rdyf = 1;
    for (int i = 0; i < IDLE + 1; i++) step();
    check("pf_idle", pf, 1'b0);
    rdyf = 0;
    wr1(8'h10, 32'h5); step();
    check("pf_wake", pf, 1'b1);

    wr1(8'h30, 32'h1); step();
    check("pm_on", pm, 1'b1);
    wr1(8'h30, 32'h0); step();
    check("pm_off", pm, 1'b0);

    db1 = 32'h8000_0010; step();
    stop = 1; db1 = 32'h7;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stop_tpe", tpe11, 1'b0);
    end
    check("stop_reg", dut.regs[3], 32'h5);
    db1 = 32'h8000_0010; step();
    stop = 0; step();

    db1 = 32'h8000_0021; step();
    masrst = 1; step();
    masrst = 0; db1 = 32'h55; step(); step();
    check("rst_addr_tpe", tpe11, 1'b0);
    check("rst_addr_reg", dut.regs[5], 32'h0);

`ifdef DAP_PORT2_EN
    s2 = 1; db1 = 32'h8000_0010; db2 = 32'h8000_0010; step();
    db1 = 32'h1; db2 = 32'h2; step();
    check("p1_wins", dut.regs[3], 32'h1);
    check("p1_wins_tp", tp11, 32'h1000_0001);
`else
    s1 = 0; s2 = 1; db2 = 32'h8000_0041; step();
    db2 = 32'h9; step(); step();
    check("p2_ignored", dut.regs[10], 32'h0);
    check("p2_no_tpe", tpe11, 1'b0);
    s1 = 1;
`endif

    for (int n = 0; n < 2000; n++) begin
      db1    = rand_word(db1);
      db2    = rand_word(db2);
      s1     = ($urandom_range(9) != 0);
      s2     = $urandom_range(1);
      stop   = ($urandom_range(19) == 0);
      if ($urandom_range(19) == 0) rdyf = ~rdyf;
      if ($urandom_range(19) == 0) donea = ~donea;
      if ($urandom_range(19) == 0) ints = ~ints;
      if ($urandom_range(9) == 0) paused = ~paused;
      respmc = ($urandom_range(99) == 0);
      masrst = ($urandom_range(199) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
